// File: rtl/hamming_secded_ctrl.sv
// hamming_secded_ctrl: sequenced (8,4) SECDED encode, error injection, decode/correct, timed hold, saturating stats.
// Define HAMMING_CTRL_AUTO_EN for the self-running demo sweep of data words and injection masks.
module hamming_secded_ctrl #(
  parameter int HOLD_CYCLES = 27_000_000,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       data_in,
  input  logic [7:0]       err_mask,
  output logic             busy,
  output logic             done,
  output logic [7:0]       cw_tx,
  output logic [7:0]       cw_rx,
  output logic [2:0]       syn,
  output logic [1:0]       status,
  output logic [3:0]       data_out,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] dbl_cnt
);
  typedef enum logic [1:0] {IDLE, ENC, CHK, HOLD} state_t;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  state_t state;
  logic [HW-1:0] hcnt;
  logic [3:0] d_q;
  logic [7:0] m_q;
  logic [7:1] enc_hi;
  logic [7:0] enc;
  logic [7:0] corr;
  logic [2:0] syn_c;
  logic ov;
  logic hold_end;
  logic req;
  logic [3:0] req_data;
  logic [7:0] req_mask;
  assign enc_hi = {d_q[3], d_q[2], d_q[1], d_q[1] ^ d_q[2] ^ d_q[3], d_q[0],
                   d_q[0] ^ d_q[2] ^ d_q[3], d_q[0] ^ d_q[1] ^ d_q[3]};
  assign enc = {enc_hi, ^enc_hi};
  assign syn_c = {^{cw_rx[4], cw_rx[5], cw_rx[6], cw_rx[7]},
                  ^{cw_rx[2], cw_rx[3], cw_rx[6], cw_rx[7]},
                  ^{cw_rx[1], cw_rx[3], cw_rx[5], cw_rx[7]}};
  assign ov = ^cw_rx;
  // Single error: syndrome addresses the bad bit, 0 meaning the overall parity bit itself
  assign corr = ov ? cw_rx ^ (8'd1 << syn_c) : cw_rx;
  assign hold_end = (state == HOLD) && (hcnt == HW'(HOLD_CYCLES - 1));
`ifdef HAMMING_CTRL_AUTO_EN
  localparam logic [87:0] MASKS = {8'h06, 8'h03, 8'h80, 8'h40, 8'h20, 8'h10,
                                   8'h08, 8'h04, 8'h02, 8'h01, 8'h00};
  logic [3:0] a_idx;
  logic [3:0] m_idx;
  logic unused_ext;
  assign unused_ext = ^{start, data_in, err_mask};
  assign req = 1'b1;
  assign req_data = a_idx;
  assign req_mask = MASKS[{m_idx, 3'b000} +: 8];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_idx <= '0;
      m_idx <= '0;
    end else if (hold_end) begin
      a_idx <= a_idx + 4'd1;
      m_idx <= (m_idx == 4'd10) ? 4'd0 : m_idx + 4'd1;
    end
`else
  assign req = start;
  assign req_data = data_in;
  assign req_mask = err_mask;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      hcnt <= '0;
      d_q <= '0;
      m_q <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      cw_tx <= '0;
      cw_rx <= '0;
      syn <= '0;
      status <= '0;
      data_out <= '0;
      corr_cnt <= '0;
      dbl_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (req) begin
          state <= ENC;
          busy <= 1'b1;
          d_q <= req_data;
          m_q <= req_mask;
        end
        ENC: begin
          cw_tx <= enc;
          cw_rx <= enc ^ m_q;
          state <= CHK;
        end
        CHK: begin
          syn <= syn_c;
          status <= ov ? 2'b01 : (|syn_c ? 2'b10 : 2'b00);
          data_out <= {corr[7:5], corr[3]};
          if (ov && !(&corr_cnt)) corr_cnt <= corr_cnt + 1'b1;
          if (!ov && |syn_c && !(&dbl_cnt)) dbl_cnt <= dbl_cnt + 1'b1;
          done <= 1'b1;
          hcnt <= '0;
          state <= HOLD;
        end
        HOLD: if (hold_end) begin
          state <= IDLE;
          busy <= 1'b0;
        end else hcnt <= hcnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule
